// File: rtl/kp_pkg.sv
// Shared types for the keypad event scanner: FSM states, the queued event
// record, and the 4x4 index-to-legend mapping used by the digit logic.
package kp_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } kp_state_t;

  // Wide enough for the largest 8x8 keypad; smaller keypads zero-extend.
  localparam int KP_MAX_CODE_W = 6;

  typedef struct packed {
    logic                     is_repeat;
    logic [KP_MAX_CODE_W-1:0] code;
  } kp_event_t;

  function automatic logic [3:0] kp_legend(input logic [3:0] code);
    logic [3:0] nib;
    case (code)
      4'd0:    nib = 4'h1;
      4'd1:    nib = 4'h2;
      4'd2:    nib = 4'h3;
      4'd3:    nib = 4'hA;
      4'd4:    nib = 4'h4;
      4'd5:    nib = 4'h5;
      4'd6:    nib = 4'h6;
      4'd7:    nib = 4'hB;
      4'd8:    nib = 4'h7;
      4'd9:    nib = 4'h8;
      4'd10:   nib = 4'h9;
      4'd11:   nib = 4'hC;
      4'd12:   nib = 4'hE;
      4'd13:   nib = 4'h0;
      4'd14:   nib = 4'hF;
      default: nib = 4'hD;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/kp_event_fifo.sv
// Small event FIFO with valid/ready drain, drop-on-full with a sticky overflow
// flag, and a registered head so the consumer sees stable data while stalled.
module kp_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_next;
  logic             full;
  logic             do_pop;
  logic             do_push;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign full    = (count == CW'(DEPTH));
  assign valid   = (count != '0);
  assign do_pop  = ready && valid;
  assign do_push = push && (!full || do_pop);
  assign rd_next = rd_ptr + 1'b1;

  always_ff @(posedge CLOCK_50) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_data <= '0;
      overflow  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_next;

      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (push && full && !do_pop) overflow <= 1'b1;

      // Head register: next stored entry after a pop, or the incoming event
      // when it lands in an otherwise empty FIFO.
      if (do_pop) begin
        if (count == CW'(1)) begin
          if (do_push) head_data <= push_data;
        end else begin
          head_data <= mem[rd_next];
        end
      end else if (!valid && do_push) begin
        head_data <= push_data;
      end
    end
  end

endmodule

// File: rtl/keypad_event_scanner.sv
// Matrix keypad front end: column scan, press/release debounce, optional
// auto-repeat, with events queued for a valid/ready consumer.
module keypad_event_scanner
  import kp_pkg::*;
#(
  parameter int NROWS      = 4,
  parameter int NCOLS      = 4,
  parameter int SCAN_DIV   = 500,
  parameter int DEB_CYCLES = 10000,
  parameter int REPEAT_EN  = 0,
  parameter int RPT_DELAY  = 25_000_000,
  parameter int RPT_RATE   = 5_000_000,
  parameter int FIFO_DEPTH = 4,
  localparam int CODE_W    = (NROWS * NCOLS > 1) ? $clog2(NROWS * NCOLS) : 1,
  localparam int FCNT_W    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              CLOCK_50,
  input  logic              Reset,
  output logic [NCOLS-1:0]  col_n,
  input  logic [NROWS-1:0]  row_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_repeat,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_held,
  output logic [FCNT_W-1:0] fifo_count,
  output logic              overflow
);

  localparam int RW      = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam int CW      = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam int DIV_W   = $clog2(SCAN_DIV + 1);
  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  kp_state_t        state;
  logic [NROWS-1:0] rs_meta;
  logic [NROWS-1:0] rs;
  logic [CW-1:0]    col;
  logic [DIV_W-1:0] div_cnt;
  logic [DEB_W-1:0] deb_cnt;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RW-1:0]    cand_r;
  logic [CW-1:0]    cand_c;
  logic             push_en;
  kp_event_t        push_ev;
  kp_event_t        head_ev;

  logic [3:0]       act_cnt;
  logic [RW-1:0]    act_row;
  logic             one_active;
  logic             cand_match;
  logic             rows_idle;
  logic             unused_head;

  function automatic logic [CW-1:0] next_col(input logic [CW-1:0] c);
    return (c == CW'(NCOLS - 1)) ? '0 : c + 1'b1;
  endfunction

  function automatic logic [KP_MAX_CODE_W-1:0] code_of(input logic [RW-1:0] r,
                                                       input logic [CW-1:0] c);
    return KP_MAX_CODE_W'(int'(r) * NCOLS + int'(c));
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (!Reset) begin
      rs_meta <= '1;
      rs      <= '1;
    end else begin
      rs_meta <= row_n;
      rs      <= rs_meta;
    end
  end

  // More than one active row in a column is a ghost/multi-key and never
  // becomes a candidate.
  always_comb begin
    act_cnt = '0;
    act_row = '0;
    for (int r = 0; r < NROWS; r++) begin
      if (!rs[r]) begin
        act_cnt = act_cnt + 4'd1;
        act_row = RW'(r);
      end
    end
  end

  assign one_active = (act_cnt == 4'd1);
  assign cand_match = (rs == ~(NROWS'(1) << cand_r));
  assign rows_idle  = &rs;
  assign col_n      = ~(NCOLS'(1) << col);

  always_ff @(posedge CLOCK_50) begin
    if (!Reset) begin
      state    <= SCAN;
      col      <= '0;
      div_cnt  <= '0;
      deb_cnt  <= '0;
      rpt_cnt  <= '0;
      cand_r   <= '0;
      cand_c   <= '0;
      push_en  <= 1'b0;
      push_ev  <= '0;
      key_held <= 1'b0;
    end else begin
      push_en <= 1'b0;
      case (state)
        SCAN: begin
          if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
            div_cnt <= '0;
            if (one_active) begin
              cand_r  <= act_row;
              cand_c  <= col;
              deb_cnt <= DEB_W'(DEB_CYCLES);
              state   <= DEBOUNCE;
            end else begin
              col <= next_col(col);
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (cand_match) begin
            if (deb_cnt == DEB_W'(1)) begin
              deb_cnt           <= '0;
              push_en           <= 1'b1;
              push_ev.is_repeat <= 1'b0;
              push_ev.code      <= code_of(cand_r, cand_c);
              rpt_cnt           <= RPT_W'(RPT_DELAY);
              key_held          <= 1'b1;
              state             <= HELD;
            end else begin
              deb_cnt <= deb_cnt - 1'b1;
            end
          end else begin
            col   <= next_col(col);
            state <= SCAN;
          end
        end

        // Column stays parked on the candidate while it is held, so keys in
        // other columns are invisible until the release completes.
        HELD: begin
          if (rs[cand_r]) begin
            deb_cnt <= DEB_W'(DEB_CYCLES);
            state   <= RELEASE;
          end else if (REPEAT_EN != 0) begin
            if (rpt_cnt == RPT_W'(1)) begin
              push_en           <= 1'b1;
              push_ev.is_repeat <= 1'b1;
              push_ev.code      <= code_of(cand_r, cand_c);
              rpt_cnt           <= RPT_W'(RPT_RATE);
            end else begin
              rpt_cnt <= rpt_cnt - 1'b1;
            end
          end
        end

        RELEASE: begin
          if (rows_idle) begin
            if (deb_cnt == DEB_W'(1)) begin
              deb_cnt  <= '0;
              col      <= next_col(col);
              key_held <= 1'b0;
              state    <= SCAN;
            end else begin
              deb_cnt <= deb_cnt - 1'b1;
            end
          end else if (cand_match) begin
            state <= HELD;
          end else begin
            key_held <= 1'b0;
            state    <= SCAN;
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

  kp_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(kp_event_t))
  ) u_fifo (
    .CLOCK_50  (CLOCK_50),
    .Reset     (Reset),
    .push      (push_en),
    .push_data (push_ev),
    .ready     (key_ready),
    .valid     (key_valid),
    .head_data (head_ev),
    .count     (fifo_count),
    .overflow  (overflow)
  );

  assign key_code    = head_ev.code[CODE_W-1:0];
  assign key_repeat  = head_ev.is_repeat;
  assign unused_head = ^head_ev.code;

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Self-checking bench: behavioural keypad matrix driving the scanner, with
// expected events derived from press timing and FIFO occupancy rules.
module tb_keypad_event_scanner;
  import kp_pkg::*;

  localparam int NR   = 4;
  localparam int NC   = 4;
  localparam int SDIV = 4;
  localparam int DEB  = 8;
  localparam int RDLY = 40;
  localparam int RRT  = 20;
  localparam int DEP  = 4;

  logic          CLOCK_50 = 1'b0;
  logic          Reset    = 1'b0;
  logic [NC-1:0] col_n;
  logic [NR-1:0] row_n;
  logic [3:0]    key_code;
  logic          key_repeat;
  logic          key_valid;
  logic          key_ready = 1'b0;
  logic          key_held;
  logic [2:0]    fifo_count;
  logic          overflow;

  logic [NR*NC-1:0] pressed = '0;
  int checks = 0;
  int passed = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  // Keypad matrix: a closed key pulls its row low while its column is driven.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (pressed[r*NC+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  keypad_event_scanner #(
    .NROWS(NR), .NCOLS(NC), .SCAN_DIV(SDIV), .DEB_CYCLES(DEB),
    .REPEAT_EN(1), .RPT_DELAY(RDLY), .RPT_RATE(RRT), .FIFO_DEPTH(DEP)
  ) dut (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .col_n(col_n), .row_n(row_n),
    .key_code(key_code), .key_repeat(key_repeat), .key_valid(key_valid),
    .key_ready(key_ready), .key_held(key_held), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic test_reset;
    Reset = 1'b0; pressed = '0; key_ready = 1'b0;
    step(2);
    checks++; if (col_n !== 4'b1110) $display("[TB] FAIL reset_col_n: got %b expected 1110", col_n); else passed++;
    checks++; if (key_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", key_valid); else passed++;
    checks++; if (fifo_count !== 3'd0) $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); else passed++;
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); else passed++;
    checks++; if (key_held !== 1'b0) $display("[TB] FAIL reset_held: got %b expected 0", key_held); else passed++;
    checks++; if ({key_repeat, key_code} !== 5'd0) $display("[TB] FAIL reset_head: got %b/%0d expected 0/0", key_repeat, key_code); else passed++;
    Reset = 1'b1;
    step(1);
  endtask

  task automatic test_single_press;
    int n = 0;
    pressed[6] = 1'b1;
    while (!key_valid && n < 200) begin step(1); n++; end
    checks++; if (key_valid !== 1'b1) $display("[TB] FAIL press_timeout: got valid=%b expected 1", key_valid); else passed++;
    checks++; if (key_code !== 4'd6) $display("[TB] FAIL press_code: got %0d expected 6", key_code); else passed++;
    checks++; if (key_repeat !== 1'b0) $display("[TB] FAIL press_repeat: got %b expected 0", key_repeat); else passed++;
    checks++; if (kp_legend(key_code) !== 4'h6) $display("[TB] FAIL press_legend: got %h expected 6", kp_legend(key_code)); else passed++;
    checks++; if (key_held !== 1'b1) $display("[TB] FAIL press_held: got %b expected 1", key_held); else passed++;
    checks++; if (fifo_count !== 3'd1) $display("[TB] FAIL press_count: got %0d expected 1", fifo_count); else passed++;
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    checks++; if (key_valid !== 1'b0) $display("[TB] FAIL press_pop: got valid=%b expected 0", key_valid); else passed++;
    step(15);
    checks++; if (fifo_count !== 3'd0) $display("[TB] FAIL press_single: got count=%0d expected 0", fifo_count); else passed++;
    pressed = '0;
    step(9);
    checks++; if (key_held !== 1'b1) $display("[TB] FAIL release_held_early: got %b expected 1", key_held); else passed++;
    step(4);
    checks++; if (key_held !== 1'b0) $display("[TB] FAIL release_held_late: got %b expected 0", key_held); else passed++;
  endtask

  task automatic test_bounce;
    int k = $urandom_range(0, NR*NC-1);
    logic [3:0] seen = '0;
    logic held_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i % 5 == 0) pressed[k] = ~pressed[k];
      step(1);
      seen |= ~col_n;
      held_seen |= key_held;
    end
    pressed = '0;
    step(20);
    checks++; if (fifo_count !== 3'd0) $display("[TB] FAIL bounce_count key=%0d: got %0d expected 0", k, fifo_count); else passed++;
    checks++; if (held_seen !== 1'b0) $display("[TB] FAIL bounce_held key=%0d: got %b expected 0", k, held_seen); else passed++;
    checks++; if (seen !== 4'hF) $display("[TB] FAIL bounce_rotate: got cols %b expected 1111", seen); else passed++;
  endtask

  task automatic test_ghost;
    int c = $urandom_range(0, NC-1);
    logic [3:0] seen = '0;
    logic held_seen = 1'b0;
    pressed[0*NC+c] = 1'b1;
    pressed[2*NC+c] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      seen |= ~col_n;
      held_seen |= key_held;
    end
    checks++; if (fifo_count !== 3'd0) $display("[TB] FAIL ghost_count col=%0d: got %0d expected 0", c, fifo_count); else passed++;
    checks++; if (held_seen !== 1'b0) $display("[TB] FAIL ghost_held col=%0d: got %b expected 0", c, held_seen); else passed++;
    checks++; if (seen !== 4'hF) $display("[TB] FAIL ghost_rotate: got cols %b expected 1111", seen); else passed++;
    pressed = '0;
    step(10);
  endtask

  task automatic test_repeat;
    int n = 0;
    int t;
    int rec_t[$];
    logic [3:0] rec_c[$];
    logic rec_r[$];
    int exp_t[$];
    key_ready = 1'b1;
    pressed[5] = 1'b1;
    while (!key_valid && n < 200) begin step(1); n++; end
    checks++; if (key_valid !== 1'b1) $display("[TB] FAIL repeat_timeout: got valid=%b expected 1", key_valid); else passed++;
    rec_t.push_back(0); rec_c.push_back(key_code); rec_r.push_back(key_repeat);
    for (int i = 1; i <= 181; i++) begin
      if (i == 122) pressed = '0;
      step(1);
      if (key_valid) begin rec_t.push_back(i); rec_c.push_back(key_code); rec_r.push_back(key_repeat); end
    end
    key_ready = 1'b0;
    // Press at 0, first repeat after the delay, then one per rate while held.
    exp_t.push_back(0);
    t = RDLY;
    while (t <= 121) begin exp_t.push_back(t); t += RRT; end
    checks++; if (rec_t.size() !== exp_t.size()) $display("[TB] FAIL repeat_events: got %0d expected %0d", rec_t.size(), exp_t.size()); else passed++;
    for (int i = 0; i < exp_t.size() && i < rec_t.size(); i++) begin
      checks++; if (rec_t[i] !== exp_t[i]) $display("[TB] FAIL repeat_time[%0d]: got +%0d expected +%0d", i, rec_t[i], exp_t[i]); else passed++;
      checks++; if (rec_c[i] !== 4'd5) $display("[TB] FAIL repeat_code[%0d]: got %0d expected 5", i, rec_c[i]); else passed++;
      checks++; if (rec_r[i] !== (i > 0)) $display("[TB] FAIL repeat_flag[%0d]: got %b expected %b", i, rec_r[i], (i > 0)); else passed++;
    end
    checks++; if (key_held !== 1'b0) $display("[TB] FAIL repeat_release: got held=%b expected 0", key_held); else passed++;
  endtask

  task automatic test_fifo_overflow;
    int picks[6];
    int exp_q[$];
    logic exp_ovf = 1'b0;
    int n;
    bit dup;
    for (int i = 0; i < 6; i++) begin
      do begin
        picks[i] = $urandom_range(0, NR*NC-1);
        dup = 0;
        for (int j = 0; j < i; j++) if (picks[j] == picks[i]) dup = 1;
      end while (dup);
    end
    key_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pressed[picks[i]] = 1'b1;
      n = 0;
      while (!key_held && n < 200) begin step(1); n++; end
      checks++; if (key_held !== 1'b1) $display("[TB] FAIL fifo_press%0d_timeout: got held=%b expected 1", i, key_held); else passed++;
      if (exp_q.size() < DEP) exp_q.push_back(picks[i]); else exp_ovf = 1'b1;
      step(3);
      pressed = '0;
      n = 0;
      while (key_held && n < 50) begin step(1); n++; end
    end
    checks++; if (fifo_count !== 3'(exp_q.size())) $display("[TB] FAIL fifo_full_count: got %0d expected %0d", fifo_count, exp_q.size()); else passed++;
    checks++; if (overflow !== exp_ovf) $display("[TB] FAIL fifo_overflow: got %b expected %b", overflow, exp_ovf); else passed++;
    checks++; if (key_code !== 4'(exp_q[0])) $display("[TB] FAIL fifo_head: got %0d expected %0d", key_code, exp_q[0]); else passed++;
    // Push and pop meet on the same edge while full.
    pressed[picks[5]] = 1'b1;
    n = 0;
    while (!key_held && n < 200) begin step(1); n++; end
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(picks[5]);
    checks++; if (fifo_count !== 3'd4) $display("[TB] FAIL pushpop_count: got %0d expected 4", fifo_count); else passed++;
    checks++; if (overflow !== exp_ovf) $display("[TB] FAIL pushpop_overflow: got %b expected %b", overflow, exp_ovf); else passed++;
    step(2);
    pressed = '0;
    n = 0;
    while (key_held && n < 50) begin step(1); n++; end
    for (int i = 0; i < DEP; i++) begin
      checks++; if (key_valid !== 1'b1 || key_code !== 4'(exp_q[i])) $display("[TB] FAIL drain[%0d]: got valid=%b code=%0d expected 1/%0d", i, key_valid, key_code, exp_q[i]); else passed++;
      key_ready = 1'b1;
      step(1);
    end
    key_ready = 1'b0;
    checks++; if (fifo_count !== 3'd0 || key_valid !== 1'b0) $display("[TB] FAIL drain_empty: got count=%0d valid=%b expected 0/0", fifo_count, key_valid); else passed++;
  endtask

  task automatic test_reset_mid;
    int n = 0;
    pressed[$urandom_range(0, NR*NC-1)] = 1'b1;
    while (!key_valid && n < 200) begin step(1); n++; end
    Reset = 1'b0;
    step(2);
    pressed = '0;
    checks++; if (fifo_count !== 3'd0 || key_valid !== 1'b0) $display("[TB] FAIL midreset_fifo: got count=%0d valid=%b expected 0/0", fifo_count, key_valid); else passed++;
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL midreset_overflow: got %b expected 0", overflow); else passed++;
    checks++; if (key_held !== 1'b0) $display("[TB] FAIL midreset_held: got %b expected 0", key_held); else passed++;
    checks++; if (col_n !== 4'b1110) $display("[TB] FAIL midreset_col_n: got %b expected 1110", col_n); else passed++;
    Reset = 1'b1;
    step(2);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_ghost();
    test_repeat();
    test_fifo_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
